bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Round-robin owner selection for the shared 8-bit data bus. Each bus driver (counter, registers, memory)
//   has its own oe input. This block generates those oe strobes so that exactly one driver is enabled at a time.
//   An idle turnaround gap separates consecutive owners, so tristate drivers never contend.
//   The block sits directly upstream of every driver's oe pin.
// PARAMETERS
//   N_REQ        4   number of bus drivers (requesters); legal range 2..16
//   MAX_HOLD     8   maximum consecutive cycles one owner keeps the bus; 0 = unlimited
//   TURN_CYCLES  1   all-oe-low cycles between two grants; legal range 1..7
// PORTS
//   clk           in   1       single clock, rising edge
//   reset_n       in   1       asynchronous, active-low reset
//   req           in   N_REQ   req[i]=1: driver i wants the bus; level-held until done
//   req_mask      in   N_REQ   req_mask[i]=1: requester i is ignored (treated as req[i]=0)
//   oe            out  N_REQ   one-hot-or-zero output enables, registered; wire oe[i] to driver i
//   owner         out  IDX_W   index of the current owner; 0 when no owner (qualify with busy)
//   busy          out  1       1 while any oe bit is high
//   hold_expired  out  1       one-cycle pulse: a grant ended because of MAX_HOLD, not release
// BEHAVIOUR
//   Reset (async, while reset_n=0): state=IDLE, oe=0, owner=0, busy=0, hold_expired=0, rr_ptr=0,
//     hold_cnt=0, turn_cnt=0. Assertion mid-grant drops oe immediately, without waiting for a clock.
//   Effective request: ereq = req & ~req_mask.
//   Winner: the first set bit of ereq, searching cyclically from rr_ptr upward (wrapping N_REQ-1 -> 0).
//   FSM (all outputs are registered and change only on the clk edge):
//     IDLE: ereq!=0 at edge k -> GRANT. oe[w]=1, owner=w and busy=1 are visible from edge k,
//       so grant latency is 1 cycle. hold_cnt=0.
//     GRANT (owner i), at each edge:
//       ereq[i]=0 (release or newly masked) -> TURN. oe=0, rr_ptr=(i+1)%N_REQ.
//       else MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> TURN. oe=0, rr_ptr=(i+1)%N_REQ, hold_expired=1 for 1 cycle.
//       else stay in GRANT, hold_cnt++.
//       Result: an owner drives the bus for at most MAX_HOLD cycles.
//     TURN: hold for TURN_CYCLES cycles with oe=0. On the last cycle, arbitrate exactly as in IDLE:
//       a winner -> GRANT, otherwise -> IDLE.
//   Fairness: an expired owner that still requests is re-granted only after every other pending requester has been served once.
//     When it is the sole requester, it is re-granted right after TURN.
//   Changes to req/req_mask while in TURN take effect at the arbitration edge. No request is latched earlier.
//   Invariant: popcount(oe)<=1 in every cycle. No cycle has oe going 1->1 between different owners.
//   Widths: IDX_W=$clog2(N_REQ). hold_cnt has width $clog2(MAX_HOLD+1). turn_cnt is 3 bits.
//     rr_ptr wraps modulo N_REQ; for non-power-of-two N_REQ, use an explicit compare, not overflow.
// STRUCTURE
//   bus_defs.vh (shared include): FSM state encodings IDLE/GRANT/TURN and the 8-bit bus width constant.
//     The counter and other bus drivers use the same file.
//   Sub-module rr_pick: combinational cyclic priority picker.
//     Inputs: ereq, rr_ptr. Outputs: found, win_idx.
//     Instantiated once. All registers stay in bus_arbiter.
// TESTING
//   1. Reset: reset_n=0 with req=4'b1111 -> oe=0, busy=0. Release reset -> oe=4'b0001 after 1 edge.
//   2. Round-robin: req=4'b1010 held, MAX_HOLD=8 -> grant sequence 1,3,1,3, each 8 cycles,
//      1 idle cycle between grants, hold_expired pulses 4 times.
//   3. Early release: owner 2 drops req after 3 cycles -> oe[2] low at the next edge.
//      Pending req[0] is granted after 1 TURN cycle. rr_ptr=3 means 3 wins over 0 if both are pending.
//   4. Mask mid-grant: owner 0 active, req_mask=4'b0001 -> oe[0] falls at the next edge, hold_expired stays 0.
//   5. Async reset mid-grant: drop reset_n between edges -> oe=0 within the same cycle, FSM in IDLE.
//   6. Sole requester, MAX_HOLD=2, TURN_CYCLES=3: req=4'b0100 held -> oe pattern 2 on, 3 off, repeating.
//      Check popcount(oe)<=1 in every cycle.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_arbiter_pkg                                               |
// | Purpose  : Shared definitions for the 8-bit data bus and its arbiter:    |
// |            bus width constant and the arbiter FSM state encoding.        |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package bus_arbiter_pkg;

  // Width of the shared tristate data bus that the granted driver owns.
  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_arbiter_rr_pick                                           |
// | Purpose  : Combinational cyclic priority picker. Returns the first set   |
// |            bit of ereq searching upward from rr_ptr, wrapping at N_REQ.  |
// | Ports    : ereq    in  N_REQ  effective requests                         |
// |            rr_ptr  in  IDX_W  search start index                         |
// |            found   out 1      at least one request present               |
// |            win_idx out IDX_W  winning index (0 when found=0)             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bus_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] ereq,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);

  // One extra bit so rr_ptr + k never overflows before the wrap compare;
  // the explicit compare keeps non-power-of-two N_REQ correct.
  logic [IDX_W:0] cand;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && ereq[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_arbiter                                                   |
// | Purpose  : Round-robin owner selection for the shared 8-bit data bus.    |
// |            Drives one-hot-or-zero registered oe strobes with an idle     |
// |            turnaround gap between owners and an optional hold limit.     |
// | Ports    : clk          in  1      rising-edge clock                     |
// |            reset_n      in  1      asynchronous active-low reset         |
// |            req          in  N_REQ  level-held bus requests               |
// |            req_mask     in  N_REQ  1 = ignore that requester             |
// |            oe           out N_REQ  registered output enables             |
// |            owner        out IDX_W  current owner index, 0 when none      |
// |            busy         out 1      any oe bit high                       |
// |            hold_expired out 1      pulse: grant ended by MAX_HOLD        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int MAX_HOLD    = 8,
  parameter  int TURN_CYCLES = 1,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_mask,
  output logic [N_REQ-1:0] oe,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             hold_expired
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  oe_q, oe_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              hold_expired_q, hold_expired_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]        turn_cnt_q, turn_cnt_d;

  logic [N_REQ-1:0]  ereq;
  logic              found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  next_ptr;

  assign ereq = req & ~req_mask;

  bus_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .ereq    (ereq),
    .rr_ptr  (rr_ptr_q),
    .found   (found),
    .win_idx (win_idx)
  );

  // Pointer moves just past the departing owner so every other pending
  // requester is served before it can win again.
  assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d        = state_q;
    oe_d           = oe_q;
    owner_d        = owner_q;
    busy_d         = busy_q;
    hold_expired_d = 1'b0;
    rr_ptr_d       = rr_ptr_q;
    hold_cnt_d     = hold_cnt_q;
    turn_cnt_d     = turn_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          oe_d       = N_REQ'(1) << win_idx;
          owner_d    = win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end

      ST_GRANT: begin
        if (!ereq[owner_q]) begin
          state_d    = ST_TURN;
          oe_d       = '0;
          owner_d    = '0;
          busy_d     = 1'b0;
          rr_ptr_d   = next_ptr;
          turn_cnt_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          state_d        = ST_TURN;
          oe_d           = '0;
          owner_d        = '0;
          busy_d         = 1'b0;
          rr_ptr_d       = next_ptr;
          turn_cnt_d     = '0;
          hold_expired_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_TURN: begin
        // Requests are only sampled on the final turnaround cycle.
        if (turn_cnt_q == TURN_LAST) begin
          if (found) begin
            state_d    = ST_GRANT;
            oe_d       = N_REQ'(1) << win_idx;
            owner_d    = win_idx;
            busy_d     = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        oe_d    = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      oe_q           <= '0;
      owner_q        <= '0;
      busy_q         <= 1'b0;
      hold_expired_q <= 1'b0;
      rr_ptr_q       <= '0;
      hold_cnt_q     <= '0;
      turn_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      oe_q           <= oe_d;
      owner_q        <= owner_d;
      busy_q         <= busy_d;
      hold_expired_q <= hold_expired_d;
      rr_ptr_q       <= rr_ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      turn_cnt_q     <= turn_cnt_d;
    end
  end

  assign oe           = oe_q;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign hold_expired = hold_expired_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bus_arbiter                                                |
// | Purpose  : Self-checking bench for bus_arbiter. Two instances: default   |
// |            parameters, and MAX_HOLD=2 / TURN_CYCLES=3.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bus_arbiter;

  typedef struct packed {
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic       hexp;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req, req_mask, req6, mask6;
  logic [3:0] oe, oe6;
  logic [1:0] owner, owner6;
  logic       busy, busy6, hexp, hexp6;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_mask(req_mask),
    .oe(oe), .owner(owner), .busy(busy), .hold_expired(hexp)
  );

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(2), .TURN_CYCLES(3)) u_dut6 (
    .clk(clk), .reset_n(reset_n), .req(req6), .req_mask(mask6),
    .oe(oe6), .owner(owner6), .busy(busy6), .hold_expired(hexp6)
  );

  function automatic obs_t own(input int i, input logic h);
    obs_t e;
    e.oe    = 4'(1) << i;
    e.owner = 2'(i);
    e.busy  = 1'b1;
    e.hexp  = h;
    return e;
  endfunction

  function automatic obs_t idle(input logic h);
    obs_t e;
    e.oe    = 4'b0000;
    e.owner = 2'd0;
    e.busy  = 1'b0;
    e.hexp  = h;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r, input logic [3:0] r6);
    reset_n  = 1'b0;
    req      = r;
    req_mask = 4'b0000;
    req6     = r6;
    mask6    = 4'b0000;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    reset_n  = 1'b0;
    req      = 4'b1111;
    req_mask = 4'b0000;
    req6     = 4'b0000;
    mask6    = 4'b0000;
    exp_q.delete();
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(own(0, 1'b0));
    for (int c = 0; c < 3; c++) begin
      step();
      want = exp_q.pop_front();
      got  = {oe, owner, busy, hexp};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset c%0d: got oe=%b owner=%0d busy=%b hexp=%b, want oe=%b owner=%0d busy=%b hexp=%b",
                 c, got.oe, got.owner, got.busy, got.hexp, want.oe, want.owner, want.busy, want.hexp);
      end
      if (c == 1) reset_n = 1'b1;
    end
  endtask

  task automatic test_round_robin();
    obs_t got, want;
    int   pulses = 0;
    do_reset(4'b1010, 4'b0000);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(own((g % 2 == 0) ? 1 : 3, 1'b0));
      exp_q.push_back(idle(1'b1));
    end
    for (int c = 0; c < 36; c++) begin
      step();
      want = exp_q.pop_front();
      got  = {oe, owner, busy, hexp};
      if (hexp === 1'b1) pulses++;
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL round_robin c%0d: got oe=%b owner=%0d busy=%b hexp=%b, want oe=%b owner=%0d busy=%b hexp=%b",
                 c, got.oe, got.owner, got.busy, got.hexp, want.oe, want.owner, want.busy, want.hexp);
      end
    end
    n_vec++;
    if (pulses !== 4) begin
      n_bad++;
      $display("FAIL round_robin_pulses: got %0d hold_expired pulses, want 4", pulses);
    end
  endtask

  // Owner 2 releases after 3 cycles; rr_ptr becomes 3, so with req[0] alone
  // pending 0 wins, and with req[3] also pending 3 wins.
  task automatic test_early_release(input logic [3:0] pend, input int winner);
    obs_t got, want;
    do_reset(4'b0100, 4'b0000);
    for (int k = 0; k < 3; k++) exp_q.push_back(own(2, 1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(own(winner, 1'b0));
    exp_q.push_back(own(winner, 1'b0));
    for (int c = 0; c < 6; c++) begin
      step();
      want = exp_q.pop_front();
      got  = {oe, owner, busy, hexp};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL early_release_w%0d c%0d: got oe=%b owner=%0d busy=%b hexp=%b, want oe=%b owner=%0d busy=%b hexp=%b",
                 winner, c, got.oe, got.owner, got.busy, got.hexp, want.oe, want.owner, want.busy, want.hexp);
      end
      if (c == 0) req = pend | 4'b0100;
      if (c == 2) req = pend;
    end
  endtask

  task automatic test_mask();
    obs_t got, want;
    do_reset(4'b0001, 4'b0000);
    exp_q.push_back(own(0, 1'b0));
    exp_q.push_back(own(0, 1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(own(0, 1'b0));
    exp_q.push_back(own(0, 1'b0));
    for (int c = 0; c < 7; c++) begin
      step();
      want = exp_q.pop_front();
      got  = {oe, owner, busy, hexp};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL mask c%0d: got oe=%b owner=%0d busy=%b hexp=%b, want oe=%b owner=%0d busy=%b hexp=%b",
                 c, got.oe, got.owner, got.busy, got.hexp, want.oe, want.owner, want.busy, want.hexp);
      end
      if (c == 1) req_mask = 4'b0001;
      if (c == 4) req_mask = 4'b0000;
    end
  endtask

  task automatic test_async_reset();
    obs_t got, want;
    do_reset(4'b0010, 4'b0000);
    exp_q.push_back(own(1, 1'b0));
    exp_q.push_back(own(1, 1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(own(1, 1'b0));
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        // Mid-cycle assertion: outputs must drop before the next edge.
        #3;
        reset_n = 1'b0;
        #1;
      end else begin
        step();
      end
      want = exp_q.pop_front();
      got  = {oe, owner, busy, hexp};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL async_reset c%0d: got oe=%b owner=%0d busy=%b hexp=%b, want oe=%b owner=%0d busy=%b hexp=%b",
                 c, got.oe, got.owner, got.busy, got.hexp, want.oe, want.owner, want.busy, want.hexp);
      end
      if (c == 3) reset_n = 1'b1;
    end
  endtask

  task automatic test_sole_requester();
    obs_t got, want;
    do_reset(4'b0000, 4'b0100);
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(own(2, 1'b0));
      exp_q.push_back(own(2, 1'b0));
      exp_q.push_back(idle(1'b1));
      exp_q.push_back(idle(1'b0));
      exp_q.push_back(idle(1'b0));
    end
    for (int c = 0; c < 20; c++) begin
      step();
      want = exp_q.pop_front();
      got  = {oe6, owner6, busy6, hexp6};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL sole_req c%0d: got oe=%b owner=%0d busy=%b hexp=%b, want oe=%b owner=%0d busy=%b hexp=%b",
                 c, got.oe, got.owner, got.busy, got.hexp, want.oe, want.owner, want.busy, want.hexp);
      end
      n_vec++;
      if ($countones(oe6) > 1) begin
        n_bad++;
        $display("FAIL sole_req_onehot c%0d: got oe=%b, want popcount<=1", c, oe6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_release(4'b0001, 0);
    test_early_release(4'b1001, 3);
    test_mask();
    test_async_reset();
    test_sole_requester();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
